// File: rtl/sram_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM to asynchronous SRAM responder.
// Holds the responder state encoding, default bus widths and the byte-lane mask helper.
package sram_bridge_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_STROBE = 3'd1,
        WR_SETUP  = 3'd2,
        WR_STROBE = 3'd3,
        WR_HOLD   = 3'd4
    } sram_resp_state_t;

    // Expands the two byteenable bits into a 16-bit data mask (bit0 -> low byte).
    function automatic logic [SRAM_DATA_W-1:0] be_mask(input logic [1:0] byteenable);
        return {{8{byteenable[1]}}, {8{byteenable[0]}}};
    endfunction

endpackage

// File: rtl/avalon_sram_responder.sv
// Avalon-MM slave that turns single-word read/write commands into registered
// CE/OE/WE/BE strobe sequences for an external asynchronous SRAM.
module avalon_sram_responder
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int DATA_W  = SRAM_DATA_W,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        byteenable,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdataready,
    output logic [ADDR_W-1:0] sram_address,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [1:0]        sram_be_n
);

    localparam int CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    sram_resp_state_t  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdr_q, rdr_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [1:0]        be_n_q, be_n_d;
    logic              drive_q, drive_d;
    logic              accept;

    assign waitrequest = reset | (state_q != IDLE);
    assign accept      = (read | write) & ~waitrequest;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rdr_d   = 1'b0;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        be_n_d  = be_n_q;
        drive_d = drive_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = address;
                    be_d   = byteenable;
                    ce_n_d = 1'b0;
                    be_n_d = ~byteenable;
                    // A simultaneous read+write executes as a write only.
                    if (write) begin
                        wdata_d = writedata;
                        drive_d = 1'b1;
                        state_d = WR_SETUP;
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_W'(RD_WAIT);
                        state_d = RD_STROBE;
                    end
                end
            end
            RD_STROBE: begin
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = sram_data & be_mask(be_q);
                    rdr_d   = 1'b1;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = 2'b11;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = CNT_W'(WR_WAIT);
                state_d = WR_STROBE;
            end
            WR_STROBE: begin
                if (cnt_q == CNT_W'(1)) begin
                    we_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                ce_n_d  = 1'b1;
                be_n_d  = 2'b11;
                drive_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdr_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 2'b11;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rdr_q   <= rdr_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            drive_q <= drive_d;
        end
    end

    assign sram_data     = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign sram_address  = addr_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_be_n     = be_n_q;
    assign readdata      = rdata_q;
    assign readdataready = rdr_q;

endmodule

// File: tb/tb_avalon_sram_responder.sv
// Directed bench for avalon_sram_responder with a small asynchronous SRAM model.
module tb_avalon_sram_responder;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;

    logic        clock;
    logic        reset;
    logic [19:0] address;
    logic [1:0]  byteenable;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic        waitrequest;
    logic [15:0] readdata;
    logic        readdataready;
    logic [19:0] sram_address;
    wire  [15:0] sram_data;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [1:0]  sram_be_n;

    int pass_cnt = 0;
    int total_cnt = 0;

    avalon_sram_responder #(
        .ADDR_W (20),
        .DATA_W (16),
        .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .byteenable   (byteenable),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdataready(readdataready),
        .sram_address (sram_address),
        .sram_data    (sram_data),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model: byte-lane writes while WE is low, full word driven while OE is low.
    logic [15:0] mem [0:255];
    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_address[7:0]] : 16'bz;
    always @(posedge clock) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[0]) mem[sram_address[7:0]][7:0]  <= sram_data[7:0];
            if (!sram_be_n[1]) mem[sram_address[7:0]][15:8] <= sram_data[15:8];
        end
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [19:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int n;
        int k;
        int cnt_low;
        logic saw_rdr;
        read       = v.rd;
        write      = v.wr;
        address    = v.addr;
        byteenable = v.be;
        writedata  = v.wdata;
        n = 0;
        while (waitrequest && n < 20) begin tick(); n++; end
        chk({tag, "_accept"}, 32'(n < 20), 32'd1);
        tick();
        read  = 1'b0;
        write = 1'b0;
        k = 0;
        cnt_low = 0;
        saw_rdr = 1'b0;
        if (v.wr) begin
            while (waitrequest && k < 20) begin
                if (!sram_we_n) cnt_low++;
                if (readdataready) saw_rdr = 1'b1;
                tick();
                k++;
            end
            chk({tag, "_wr_idle_cycle"}, 32'(k), 32'(WR_WAIT + 2));
            chk({tag, "_we_low_cycles"}, 32'(cnt_low), 32'(WR_WAIT));
            chk({tag, "_no_rdr"}, 32'(saw_rdr | readdataready), 32'd0);
        end else begin
            while (!readdataready && k < 20) begin
                if (!sram_oe_n) cnt_low++;
                tick();
                k++;
            end
            chk({tag, "_rd_latency"}, 32'(k), 32'(RD_WAIT));
            chk({tag, "_oe_low_cycles"}, 32'(cnt_low), 32'(RD_WAIT));
            chk({tag, "_rdata"}, 32'(readdata), 32'(v.exp));
            tick();
            chk({tag, "_rdr_one_cycle"}, 32'(readdataready), 32'd0);
        end
    endtask

    logic [19:0] str_addr [3];
    logic [15:0] str_exp [3];

    initial begin
        vec_t rv;
        int idx, np, wr_low, last, seen;

        vecs[0]  = '{1'b1, 1'b0, 20'h0000A, 2'b11, 16'hAABB, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 20'h0000A, 2'b11, 16'h0000, 16'hAABB};
        vecs[2]  = '{1'b1, 1'b0, 20'h0000B, 2'b11, 16'hFFFF, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 20'h0000B, 2'b01, 16'h1122, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 20'h0000B, 2'b11, 16'h0000, 16'hFF22};
        vecs[5]  = '{1'b0, 1'b1, 20'h0000B, 2'b10, 16'h0000, 16'hFF00};
        vecs[6]  = '{1'b1, 1'b0, 20'h0000C, 2'b11, 16'h0099, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 20'h0000B, 2'b11, 16'h1122, 16'h0000};
        vecs[8]  = '{1'b1, 1'b1, 20'h0000D, 2'b11, 16'h5A5A, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 20'h0000D, 2'b11, 16'h0000, 16'h5A5A};
        vecs[10] = '{1'b0, 1'b1, 20'h0000A, 2'b00, 16'h0000, 16'h0000};

        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; byteenable = 2'b11; writedata = '0;
        tick(); tick();
        chk("rst_waitrequest", 32'(waitrequest), 32'd1);
        chk("rst_rdr", 32'(readdataready), 32'd0);
        chk("rst_readdata", 32'(readdata), 32'd0);
        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}), 32'h1F);
        chk("rst_address", 32'(sram_address), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_waitrequest", 32'(waitrequest), 32'd0);

        for (int i = 0; i < 11; i++) run_cmd(vecs[i], $sformatf("v%0d", i));

        // Back-to-back reads with read held high.
        str_addr[0] = 20'h0000C; str_exp[0] = 16'h0099;
        str_addr[1] = 20'h0000B; str_exp[1] = 16'h1122;
        str_addr[2] = 20'h0000A; str_exp[2] = 16'hAABB;
        read = 1'b1; write = 1'b0; byteenable = 2'b11; address = str_addr[0];
        idx = 0; np = 0; wr_low = 0; last = -1;
        for (int c = 0; c < 30; c++) begin
            if (readdataready) begin
                if (np < 3) chk($sformatf("stream_data%0d", np), 32'(readdata), 32'(str_exp[np]));
                if (np > 0) chk($sformatf("stream_gap%0d", np), 32'(c - last), 32'(RD_WAIT + 1));
                last = c;
                np++;
            end
            if (read && !waitrequest) begin wr_low++; idx++; end
            tick();
            if (idx < 3) address = str_addr[idx];
            else read = 1'b0;
        end
        chk("stream_pulses", 32'(np), 32'd3);
        chk("stream_wr_low_cycles", 32'(wr_low), 32'd3);

        // Reset while WE is low.
        address = 20'h00020; writedata = 16'h1234; byteenable = 2'b11; write = 1'b1;
        seen = 0;
        while (waitrequest && seen < 20) begin tick(); seen++; end
        tick();
        write = 1'b0;
        tick();
        chk("wrst_in_strobe", 32'(sram_we_n), 32'd0);
        reset = 1'b1;
        tick();
        chk("wrst_strobes_high", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}), 32'h1F);
        chk("wrst_waitrequest", 32'(waitrequest), 32'd1);
        tick();
        chk("wrst_waitrequest_held", 32'(waitrequest), 32'd1);
        reset = 1'b0;
        rv = '{1'b0, 1'b1, 20'h0000A, 2'b11, 16'h0000, 16'hAABB};
        run_cmd(rv, "after_wrst");

        // Reset while OE is low: the read must never complete.
        address = 20'h0000C; read = 1'b1;
        seen = 0;
        while (waitrequest && seen < 20) begin tick(); seen++; end
        tick();
        read = 1'b0;
        chk("rrst_in_strobe", 32'(sram_oe_n), 32'd0);
        reset = 1'b1;
        tick();
        chk("rrst_oe_high", 32'(sram_oe_n), 32'd1);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (readdataready) seen++;
            tick();
        end
        chk("rrst_no_rdr", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
